// File: rtl/scu_wdt_rst_req_gen_if.sv
// Watchdog control/status bundle between the SCU register block and the reset-request generator.
// Latency: none, wires only.
// Backpressure: none. Level and pulse signals only, with no handshake.
interface scu_wdt_rst_req_gen_if #(
  parameter int CNT_W = 32
);
  logic             wdt_en_i;
  logic [CNT_W-1:0] wdt_load_i;
  logic             wdt_kick_i;
  logic             wdt_int_clr_i;
  logic             wdt_flag_clr_i;
  logic             main_all_reset_release_i;
  logic             wdt_irq_o;
  logic             wdt_rst_req_o;
  logic             wdt_rst_flag_o;
  logic [CNT_W-1:0] wdt_cnt_o;

  // Register block / boot FSM side
  modport master (
    output wdt_en_i, wdt_load_i, wdt_kick_i, wdt_int_clr_i, wdt_flag_clr_i,
           main_all_reset_release_i,
    input  wdt_irq_o, wdt_rst_req_o, wdt_rst_flag_o, wdt_cnt_o
  );

  // Watchdog side
  modport slave (
    input  wdt_en_i, wdt_load_i, wdt_kick_i, wdt_int_clr_i, wdt_flag_clr_i,
           main_all_reset_release_i,
    output wdt_irq_o, wdt_rst_req_o, wdt_rst_flag_o, wdt_cnt_o
  );
endinterface

// File: rtl/scu_wdt_rst_req_gen.sv
// Two-stage watchdog: stage-1 timeout raises irq, stage-2 timeout raises a held reset request (optional WDT_LOCK_EN lock).
// Latency: all outputs are registered; irq rises load+1 cycles after STAGE1 entry, and rst_req rises load+1 cycles after that.
// Backpressure: none. The request is held until release drops for REQ_HOLD_CNT cycles, then the block waits for re-release.
module scu_wdt_rst_req_gen #(
  parameter int CNT_W        = 32,
  parameter int REQ_HOLD_CNT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  scu_wdt_rst_req_gen_if.slave  wdt_if
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STAGE1   = 3'd1,
    STAGE2   = 3'd2,
    RST_REQ  = 3'd3,
    RST_WAIT = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(REQ_HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt,   w_cnt_n;
  logic [7:0]       r_hold,  w_hold_n;
  logic             r_irq,   w_irq_n;
  logic             r_req,   w_req_n;
  logic             r_flag,  w_flag_n;
  logic             w_en_eff;
  logic             w_rel;

  assign w_rel = wdt_if.main_all_reset_release_i;

`ifdef WDT_LOCK_EN
  logic r_lock, w_lock_n;

  // Once armed, the lock keeps the watchdog running until por reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_lock <= 1'b0;
    else          r_lock <= w_lock_n;
  end

  assign w_en_eff = wdt_if.wdt_en_i | r_lock;
`else
  assign w_en_eff = wdt_if.wdt_en_i;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_irq   <= 1'b0;
      r_req   <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_hold  <= w_hold_n;
      r_irq   <= w_irq_n;
      r_req   <= w_req_n;
      r_flag  <= w_flag_n;
    end
  end

  // Next-state and next-output logic; the clear pulses form the defaults so that same-cycle set events override them
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_hold_n  = r_hold;
    w_req_n   = r_req;
    w_irq_n   = wdt_if.wdt_int_clr_i  ? 1'b0 : r_irq;
    w_flag_n  = wdt_if.wdt_flag_clr_i ? 1'b0 : r_flag;
`ifdef WDT_LOCK_EN
    w_lock_n  = r_lock;
`endif

    case (r_state)
      IDLE: begin
        w_cnt_n  = wdt_if.wdt_load_i;
        w_hold_n = '0;
        if (w_en_eff && w_rel) begin
          w_state_n = STAGE1;
`ifdef WDT_LOCK_EN
          w_lock_n  = 1'b1;
`endif
        end
      end

      STAGE1: begin
        if (!w_en_eff) begin
          w_state_n = IDLE;
          w_irq_n   = 1'b0;
        end else if (wdt_if.wdt_kick_i) begin
          w_cnt_n   = wdt_if.wdt_load_i;
        end else if (r_cnt == '0) begin
          w_irq_n   = 1'b1;
          w_cnt_n   = wdt_if.wdt_load_i;
          w_state_n = STAGE2;
        end else begin
          w_cnt_n   = r_cnt - CNT_ONE;
        end
      end

      STAGE2: begin
        if (!w_en_eff) begin
          w_state_n = IDLE;
          w_irq_n   = 1'b0;
        end else if (wdt_if.wdt_kick_i) begin
          w_cnt_n   = wdt_if.wdt_load_i;
          w_state_n = STAGE1;
        end else if (r_cnt == '0) begin
          w_state_n = RST_REQ;
          w_req_n   = 1'b1;
          w_flag_n  = 1'b1;
          w_irq_n   = 1'b0;
          w_hold_n  = '0;
        end else begin
          w_cnt_n   = r_cnt - CNT_ONE;
        end
      end

      RST_REQ: begin
        // The hold time runs only while the system reset is actually in progress
        if (!w_rel) begin
          if (r_hold == HOLD_LAST) begin
            w_req_n   = 1'b0;
            w_hold_n  = '0;
            w_state_n = RST_WAIT;
          end else if (r_hold != 8'hFF) begin
            w_hold_n  = r_hold + 8'd1;
          end
        end else begin
          w_hold_n = '0;
        end
      end

      RST_WAIT: begin
        if (w_rel) w_state_n = IDLE;
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign wdt_if.wdt_irq_o      = r_irq;
  assign wdt_if.wdt_rst_req_o  = r_req;
  assign wdt_if.wdt_rst_flag_o = r_flag;
  assign wdt_if.wdt_cnt_o      = r_cnt;

endmodule

// File: doc/scu_wdt_rst_req_gen.md
Name: scu_wdt_rst_req_gen

Overview:
Watchdog reset-request initiator in the SCU reset group; its output drives the boot FSM's wdt_rst_req_i input.
- Two-stage down-counter: first timeout raises an interrupt, second timeout issues a reset request.
- Holds the request through the system-reset handshake: the request stays high until main_all_reset_release drops and a minimum hold time expires, then the block waits for re-release before re-arming.
- Sits on the POR-synchronised reset, so the block and its flag survive the reset it requests.

Parameters:
CNT_W, 32, width of load value and down-counter
REQ_HOLD_CNT, 16, minimum cycles wdt_rst_req_o stays high after main_all_reset_release_i is seen low (1..255)

Ports:
clk_i  input  1  SCU kernel clock
rst_n_i  input  1  por_rstn_sync, asynchronous active-low
wdt_en_i  input  1  watchdog enable (SCU register, level)
wdt_load_i  input  CNT_W  reload value (SCU register)
wdt_kick_i  input  1  single-cycle feed pulse
wdt_int_clr_i  input  1  single-cycle interrupt clear pulse
wdt_flag_clr_i  input  1  single-cycle reset-flag clear pulse
main_all_reset_release_i  input  1  all-reset-release from boot FSM
wdt_irq_o  output  1  first-stage timeout interrupt, level
wdt_rst_req_o  output  1  reset request to boot FSM
wdt_rst_flag_o  output  1  sticky "watchdog reset occurred" status
wdt_cnt_o  output  CNT_W  current counter value, read-only status

Behaviour:
Reset values:
- All outputs 0.
- State IDLE; counter 0; hold counter 0.
- All outputs are registered.

States: IDLE, STAGE1, STAGE2, RST_REQ, RST_WAIT.

IDLE:
- cnt <= wdt_load_i every cycle.
- When wdt_en_i=1 and main_all_reset_release_i=1, go to STAGE1.

STAGE1:
- If cnt != 0: cnt <= cnt - 1.
- If cnt == 0: wdt_irq_o <= 1, cnt <= wdt_load_i, go to STAGE2.
- With load=L held, wdt_irq_o rises L+1 cycles after entering STAGE1.

STAGE2:
- Decrements the same way.
- If cnt == 0: go to RST_REQ, wdt_rst_req_o <= 1, wdt_rst_flag_o <= 1, wdt_irq_o <= 0.

Kick in STAGE1 or STAGE2:
- cnt <= wdt_load_i and state goes to STAGE1.
- wdt_irq_o is unchanged; it is cleared only by wdt_int_clr_i.
- Kick has priority over a same-cycle timeout.
- Kick is ignored in IDLE, RST_REQ and RST_WAIT.

wdt_en_i=0 in STAGE1 or STAGE2: go to IDLE and clear wdt_irq_o. This has priority over both kick and timeout.

Load value 0: each stage times out on its first cycle, giving irq one cycle after STAGE1 entry.

RST_REQ:
- wdt_rst_req_o is held at 1.
- The hold counter increments, saturating, only while main_all_reset_release_i=0; otherwise it resets to 0.
- When main_all_reset_release_i=0 and hold == REQ_HOLD_CNT-1: wdt_rst_req_o <= 0, go to RST_WAIT.
- wdt_en_i and wdt_kick_i are ignored.
- If release never drops, the block stays in RST_REQ indefinitely.

RST_WAIT:
- When main_all_reset_release_i=1, go to IDLE.
- Re-arming then requires wdt_en_i=1, so the counter restarts from the fresh load.

Clear pulses:
- wdt_int_clr_i clears wdt_irq_o. A same-cycle stage-1 timeout wins: irq set.
- wdt_flag_clr_i clears wdt_rst_flag_o. A same-cycle entry to RST_REQ wins: flag set.

Other rules:
- wdt_cnt_o = cnt.
- Counter arithmetic is unsigned CNT_W; there is no wrap below 0 because 0 triggers reload.
- Reset mid-operation (rst_n_i low): immediate return to reset values, including the flag.

Optional Feature:
WDT_LOCK_EN
- Defined: a lock bit sets on the first IDLE-to-STAGE1 transition and clears only on rst_n_i.
  - While locked, wdt_en_i=0 is ignored in STAGE1 and STAGE2.
  - RST_WAIT to IDLE re-enters STAGE1 automatically once release is high, regardless of wdt_en_i.
- Undefined: no lock bit; wdt_en_i behaves as described above.

Test Plan:
- Load=10, en=1, release=1, no kick -> irq high 11 cycles after STAGE1 entry; rst_req high 11 cycles later; flag=1; irq=0.
- Load=10, kick every 8 cycles for 200 cycles -> irq and rst_req never assert; cnt never below 2.
- Load=10, reach STAGE2, kick at cnt=3 -> back to STAGE1 with cnt=10; irq stays 1 until int_clr pulse, then 0.
- Rst_req asserted, release held high 50 cycles then dropped -> req stays high exactly REQ_HOLD_CNT=16 cycles after the drop, then 0. Release high again -> IDLE; flag still 1 until flag_clr.
- En dropped at cnt=5 in STAGE1 -> IDLE next cycle, irq=0, cnt follows load. With WDT_LOCK_EN -> counting continues, timeout reached.
- Load=0, en=1 -> irq 1 cycle after STAGE1 entry, rst_req 1 cycle later. Same-cycle int_clr and stage-1 timeout -> irq=1.
